riscv_lsu: RTL
==============

Name: riscv_lsu

Overview:
- Load-store unit between `riscv_core` and the data memory.
- Converts core accesses (`mem_size`/funct3, byte address, raw store data) into word-aligned memory requests with byte enables and lane-replicated store data.
- Sign- or zero-extends load data and generates the core stall.
- Detects misaligned, illegal-size and timed-out accesses, and reports them on `core_err_o`.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of WAIT cycles without `mem_ready_i` before the access is aborted with an error.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset, asynchronous and active-low (one clock; reset asynchronous active-low)
- core_req_i  input  1  core requests a memory access; held stable by the core while `core_stall_o`=1
- core_we_i  input  1  1 = store, 0 = load
- core_size_i  input  3  funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU; 3/6/7 illegal; 4/5 illegal for stores
- core_addr_i  input  32  byte address
- core_wd_i  input  32  store data, right-aligned
- core_rd_o  output  32  extended load data; valid in RESP
- core_stall_o  output  1  core must hold its state
- core_err_o  output  1  one-cycle pulse in RESP on misaligned, illegal-size or timeout
- mem_req_o  output  1  memory request
- mem_we_o  output  1  memory write enable
- mem_be_o  output  4  byte enables
- mem_addr_o  output  32  word address, {core_addr_i[31:2], 2'b00}
- mem_wd_o  output  32  lane-replicated store data
- mem_rd_i  input  32  memory read word
- mem_ready_i  input  1  memory completed the access this cycle

Behaviour:
- FSM states: IDLE, WAIT, RESP. Registers:
  - state
  - timeout counter, width $clog2(TIMEOUT_CYCLES)+1
  - rd_q[31:0]
  - err_q
  - latched size_q[2:0], offset_q[1:0], we_q
- Reset (`rst_i`=0, async):
  - State goes to IDLE; counter, rd_q, err_q and latches go to 0.
  - All outputs are forced to 0 while `rst_i`=0, including `core_stall_o` and `mem_req_o`.
- Fault detection:
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
  - Illegal: size 3/6/7, or `core_we_i`=1 with size 4/5.
- IDLE, `core_req_i`=1 and no fault:
  - `mem_req_o`=1, combinational from core inputs.
  - Latch size/offset/we; go to WAIT.
  - `core_stall_o`=1.
- IDLE, `core_req_i`=1 with a fault:
  - `mem_req_o`=0; set err_q=1, rd_q=0; go to RESP.
  - `core_stall_o`=1.
- IDLE, `core_req_i`=0: all outputs 0.
- WAIT:
  - `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o` and `mem_wd_o` are held, driven from the still-stable core inputs.
  - `core_stall_o`=1; the counter increments every cycle.
  - `mem_ready_i`=1: on a load, capture the extended `mem_rd_i` into rd_q; on a store, rd_q=0. Go to RESP; err_q=0.
  - Counter reaches TIMEOUT_CYCLES with no ready: deassert `mem_req_o`, err_q=1, rd_q=0, go to RESP. A ready arriving in the same cycle as expiry wins (normal completion).
- RESP:
  - `core_stall_o`=0, `core_rd_o`=rd_q, `core_err_o`=err_q, `mem_req_o`=0.
  - Unconditionally go to IDLE and clear the counter; `core_req_i` is ignored this cycle, since the core retires the instruction at this edge.
- `mem_ready_i` is ignored outside WAIT.
- Minimum access time: 3 cycles (IDLE issue, WAIT with ready, RESP), i.e. 2 stall cycles. A faulted access takes 2 cycles.
- Store formatting:
  - SB: be = 4'b0001 << addr[1:0]; wd = {4{wd[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{wd[15:0]}}.
  - SW: be = 4'b1111; wd unchanged.
- Loads:
  - be = 4'b1111, we = 0.
  - Select byte/halfword by offset_q; sign-extend for B/H, zero-extend for BU/HU; W passes through.
- Outside IDLE-with-request and WAIT, `mem_be_o`, `mem_wd_o` and `mem_addr_o` are 0.
- Reset asserted in WAIT aborts the access: `mem_req_o` drops immediately, and after release the FSM is in IDLE.

Test Plan:
- LW at 0x100 with memory returning 0xDEADBEEF with `mem_ready_i` on the first WAIT cycle -> `mem_addr_o`=0x100, be=1111, stall for 2 cycles, `core_rd_o`=0xDEADBEEF in RESP, `core_err_o`=0.
- LB at 0x103, mem word 0x80112233 -> `core_rd_o`=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x00008011.
- SH at 0x206 with wd 0x0000ABCD -> `mem_addr_o`=0x204, be=1100, `mem_wd_o`=0xABCDABCD, `mem_we_o`=1.
- LW at 0x102 -> `mem_req_o` never asserted; RESP on the next cycle with `core_err_o`=1 and `core_rd_o`=0. SB with size 3 -> same error behaviour.
- Load with `mem_ready_i` held at 0 -> after 16 WAIT cycles, RESP with `core_err_o`=1. Repeat with ready arriving on cycle 16 -> normal data, no error.
- Back-to-back LW/SW with ready always high -> each access completes in 3 cycles with no duplicate `mem_req_o` in RESP. Drop `rst_i` mid-WAIT -> all outputs are 0 asynchronously, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load-store unit: turns core byte accesses into word-aligned memory requests,
// formats store lanes, extends load data, and flags faulted or timed-out accesses.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_q, rd_d;
  logic             err_q, err_d;
  logic [2:0]       size_q, size_d;
  logic [1:0]       off_q, off_d;
  logic             we_q, we_d;

  logic             fault_c;
  logic             misaligned_c;
  logic             illegal_c;
  logic [3:0]       be_fmt_c;
  logic [31:0]      wd_fmt_c;
  logic [31:0]      ld_ext_c;
  logic [7:0]       ld_byte_c;
  logic [15:0]      ld_half_c;
  logic             issue_c;
  logic             active_c;

  // Fault classification of the access presented by the core
  always_comb begin
    misaligned_c = 1'b0;
    illegal_c    = 1'b0;
    case (core_size_i)
      3'd0, 3'd4: misaligned_c = 1'b0;
      3'd1, 3'd5: misaligned_c = core_addr_i[0];
      3'd2:       misaligned_c = |core_addr_i[1:0];
      default:    illegal_c    = 1'b1;
    endcase
    if (core_we_i && (core_size_i == 3'd4 || core_size_i == 3'd5)) begin
      illegal_c = 1'b1;
    end
    fault_c = misaligned_c | illegal_c;
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_fmt_c = 4'b1111;
    wd_fmt_c = 32'h0;
    if (core_we_i) begin
      case (core_size_i[1:0])
        2'd0: begin
          be_fmt_c = 4'b0001 << core_addr_i[1:0];
          wd_fmt_c = {4{core_wd_i[7:0]}};
        end
        2'd1: begin
          be_fmt_c = core_addr_i[1] ? 4'b1100 : 4'b0011;
          wd_fmt_c = {2{core_wd_i[15:0]}};
        end
        default: begin
          be_fmt_c = 4'b1111;
          wd_fmt_c = core_wd_i;
        end
      endcase
    end
  end

  // Load lane select and extension using the latched size/offset
  always_comb begin
    case (off_q)
      2'd0:    ld_byte_c = mem_rd_i[7:0];
      2'd1:    ld_byte_c = mem_rd_i[15:8];
      2'd2:    ld_byte_c = mem_rd_i[23:16];
      default: ld_byte_c = mem_rd_i[31:24];
    endcase
    ld_half_c = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q)
      3'd0:    ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'd1:    ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'd4:    ld_ext_c = {24'h0, ld_byte_c};
      3'd5:    ld_ext_c = {16'h0, ld_half_c};
      default: ld_ext_c = mem_rd_i;
    endcase
  end

  assign issue_c  = (state_q == S_IDLE) && core_req_i && !fault_c;
  assign active_c = issue_c || (state_q == S_WAIT);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    size_d  = size_q;
    off_d   = off_q;
    we_d    = we_q;
    case (state_q)
      S_IDLE: begin
        if (core_req_i) begin
          if (fault_c) begin
            err_d   = 1'b1;
            rd_d    = 32'h0;
            state_d = S_RESP;
          end else begin
            size_d  = core_size_i;
            off_d   = core_addr_i[1:0];
            we_d    = core_we_i;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A ready in the expiry cycle still completes normally
        if (mem_ready_i) begin
          rd_d    = we_q ? 32'h0 : ld_ext_c;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          rd_d    = 32'h0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 32'h0;
      err_q   <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      size_q  <= size_d;
      off_q   <= off_d;
      we_q    <= we_d;
    end
  end

  // Outputs follow the held core inputs; everything is forced low during reset
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = 32'h0;
    mem_wd_o     = 32'h0;
    core_stall_o = 1'b0;
    core_rd_o    = 32'h0;
    core_err_o   = 1'b0;
    if (rst_i) begin
      if (active_c) begin
        mem_req_o  = 1'b1;
        mem_we_o   = core_we_i;
        mem_be_o   = be_fmt_c;
        mem_addr_o = {core_addr_i[31:2], 2'b00};
        mem_wd_o   = wd_fmt_c;
      end
      core_stall_o = ((state_q == S_IDLE) && core_req_i) || (state_q == S_WAIT);
      if (state_q == S_RESP) begin
        core_rd_o  = rd_q;
        core_err_o = err_q;
      end
    end
  end

endmodule
